bcd_serial_adder_ctrl: RTL and testbench

//  Digit-serial sequencer that computes an NDIG-digit packed-BCD sum using one shared single-digit BCD add stage.

---
 rtl/bcd_serial_adder_ctrl_pkg.sv | 13 +
 rtl/bcd_digit_stage.sv | 30 +++
 rtl/bcd_serial_adder_ctrl.sv | 144 ++++++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder/subtractor.
package bcd_serial_adder_ctrl_pkg;

   localparam logic [3:0] BcdMax = 4'd9;
   localparam logic [3:0] BcdAdj = 4'd6;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAdd  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/bcd_digit_stage.sv
// Single-digit combinational BCD add stage with decimal adjust and invalid-digit flag.
module bcd_digit_stage
   import bcd_serial_adder_ctrl_pkg::*;
(
   input  logic [3:0] da,
   input  logic [3:0] db,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co,
   output logic       bad
);

   logic [4:0] raw;
   logic [4:0] adj;

   always_comb begin
      // Full 5-bit sum is tested before any truncation (max 9+9+1=19).
      raw = {1'b0, da} + {1'b0, db} + {4'b0, ci};
      adj = raw + {1'b0, BcdAdj};
      if (raw > {1'b0, BcdMax}) begin
         s  = adj[3:0];
         co = 1'b1;
      end else begin
         s  = raw[3:0];
         co = 1'b0;
      end
      bad = (da > BcdMax) | (db > BcdMax);
   end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial NDIG-digit packed-BCD adder sequencer, LSD first, valid/ready in and out.
// Define BCD_SUB_EN to add the op_sub port (A-B via nines complement of B).
module bcd_serial_adder_ctrl
   import bcd_serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned NDIG = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
   input  logic              c_in,
`ifdef BCD_SUB_EN
   input  logic              op_sub,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NDIG-1:0] sum,
   output logic              c_out,
   output logic              err
);

   localparam int unsigned W    = 4 * NDIG;
   localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(NDIG - 1);

   state_e          state_q, state_d;
   logic            init_q;
   logic [W-1:0]    a_sh_q, a_sh_d;
   logic [W-1:0]    b_sh_q, b_sh_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            c_out_q, c_out_d;
   logic            err_q, err_d;
   logic            sub_q, sub_d;
   logic            sub_in;
   logic            accept;

   logic [3:0] stage_db;
   logic [3:0] stage_s;
   logic       stage_co;
   logic       stage_bad;

`ifdef BCD_SUB_EN
   assign sub_in = op_sub;
`else
   assign sub_in = 1'b0;
`endif

   // For an original B digit >9 the complement wraps above 9 as well, so the
   // stage's bad flag still reflects the original B digit.
   assign stage_db = sub_q ? (BcdMax - b_sh_q[3:0]) : b_sh_q[3:0];

   bcd_digit_stage u_digit (
      .da  (a_sh_q[3:0]),
      .db  (stage_db),
      .ci  (carry_q),
      .s   (stage_s),
      .co  (stage_co),
      .bad (stage_bad)
   );

   // init_q keeps in_ready low until the first clock after reset release.
   assign in_ready  = init_q & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
   assign accept    = in_ready & in_valid;
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign err       = err_q;

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      err_d   = err_q;
      sub_d   = sub_q;

      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StAdd;
         end
         StAdd: begin
            sum_d[cnt_q*4 +: 4] = stage_s;
            carry_d = stage_co;
            err_d   = err_q | stage_bad;
            a_sh_d  = a_sh_q >> 4;
            b_sh_d  = b_sh_q >> 4;
            if (cnt_q == CntLast) begin
               state_d = StDone;
               c_out_d = stage_co;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (out_ready) state_d = in_valid ? StAdd : StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         a_sh_d  = a;
         b_sh_d  = b;
         carry_d = sub_in ? 1'b1 : c_in;
         sub_d   = sub_in;
         cnt_d   = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         init_q  <= 1'b0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         err_q   <= 1'b0;
         sub_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         err_q   <= err_d;
         sub_q   <= sub_d;
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl: directed vector table, corner sequences,
// and random operands against an integer-arithmetic reference model.
module tb_bcd_serial_adder_ctrl;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;
   localparam int MODV = 10000;
   localparam int TMO  = 50;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         c_in = 1'b0;
   logic         op_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         c_out;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bcd_serial_adder_ctrl #(.NDIG(NDIG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
`ifdef BCD_SUB_EN
      .op_sub    (op_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .err       (err)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] esum;
      logic         ecout;
      logic         eerr;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      int t = v;
      for (int i = 0; i < NDIG; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Decimal reference: subtraction is A + (10^N - 1 - B) + 1.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                        input logic msub, output logic [W-1:0] esum, output logic ecout,
                        output logic eerr);
      int ai, bi, r;
      eerr = 1'b0;
      for (int i = 0; i < NDIG; i++)
         if (ma[i*4 +: 4] > 4'd9 || mb[i*4 +: 4] > 4'd9) eerr = 1'b1;
      ai = bcd2int(ma);
      bi = bcd2int(mb);
      r  = msub ? (ai + (MODV - 1 - bi) + 1) : (ai + bi + int'(mcin));
      ecout = (r >= MODV);
      esum  = int2bcd(r % MODV);
   endtask

   task automatic do_accept(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                            input logic vsub);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < TMO) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("accept_wait", in_ready, 1);
      a = va;
      b = vb;
      c_in = vcin;
      op_sub = vsub;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result();
      repeat (NDIG - 1) @(posedge clk);
      #1 chk("latency_early", out_valid, 0);
      @(posedge clk);
      #1 chk("latency", out_valid, 1);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      do_accept(v.a, v.b, v.cin, v.sub);
      wait_result();
      if (!v.eerr) begin
         chk({name, "_sum"}, sum, v.esum);
         chk({name, "_cout"}, c_out, v.ecout);
      end
      chk({name, "_err"}, err, v.eerr);
      consume();
   endtask

   vec_t vecs[7];
   vec_t rv;
   logic seen;
   logic [W-1:0] held;

   initial begin
      vecs[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
      vecs[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
      vecs[3] = '{16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[4] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[5] = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0};
      vecs[6] = '{16'h0505, 16'h0505, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", c_out, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      #1 chk("rel_in_ready_pre_clk", in_ready, 0);
      @(posedge clk);
      #1 chk("rel_in_ready", in_ready, 1);

      foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

`ifdef BCD_SUB_EN
      run_vec("sub_ge", '{16'h0500, 16'h0123, 1'b0, 1'b1, 16'h0377, 1'b1, 1'b0});
      run_vec("sub_lt", '{16'h0123, 16'h0500, 1'b1, 1'b1, 16'h9623, 1'b0, 1'b0});
`endif

      // Hold in DONE, then back-to-back accept
      do_accept(16'h4321, 16'h1111, 1'b0, 1'b0);
      wait_result();
      held = sum;
      chk("hold_first_sum", sum, 16'h5432);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = 16'h7777;
         in_valid = 1'b1;
         #1;
         if (sum !== held || in_ready !== 1'b0 || out_valid !== 1'b1) seen = 1'b1;
      end
      chk("hold_stable", seen, 0);
      @(negedge clk);
      a = 16'h0005;
      b = 16'h0007;
      c_in = 1'b0;
      op_sub = 1'b0;
      out_ready = 1'b1;
      #1 chk("b2b_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      wait_result();
      chk("b2b_sum", sum, 16'h0012);
      chk("b2b_err", err, 0);
      consume();

      // Reset mid-ADD at cnt==2
      do_accept(16'h0123, 16'h0456, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_err", err, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("midrst_idle", in_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < NDIG + 3; i++) begin
         @(posedge clk);
         #1 if (out_valid) seen = 1'b1;
      end
      chk("midrst_no_result", seen, 0);

      // Random operands against the decimal model
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < NDIG; i++) begin
            rv.a[i*4 +: 4] = 4'($urandom_range(0, 9));
            rv.b[i*4 +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) rv.a[$urandom_range(0, NDIG - 1)*4 +: 4] =
            4'($urandom_range(10, 15));
         if ($urandom_range(0, 7) == 0) rv.b[$urandom_range(0, NDIG - 1)*4 +: 4] =
            4'($urandom_range(10, 15));
         rv.cin = 1'($urandom_range(0, 1));
`ifdef BCD_SUB_EN
         rv.sub = 1'($urandom_range(0, 1));
`else
         rv.sub = 1'b0;
`endif
         model(rv.a, rv.b, rv.cin, rv.sub, rv.esum, rv.ecout, rv.eerr);
         run_vec($sformatf("rand%0d", n), rv);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
